product_accumulator: RTL and testbench
======================================

// Module: product_accumulator
// PURPOSE
//  Downstream stage of the 8x8 unsigned multiplier. Consumes its 16-bit products
//  over a valid/ready handshake and sums LEN consecutive products (a dot product).
//  Presents the sum with a valid/ready output handshake, then starts the next group.
//  Sits between the multiplier and the result/display logic.
// PARAMETERS
//  PROD_W  16  width of incoming product (matches multiplier output C)
//  LEN     4   products per group, >= 2
//  ACC_W   18  accumulator/sum width; ACC_W >= PROD_W+$clog2(LEN) means no overflow
// PORTS
//  clk         in   1       single clock, rising edge
//  reset       in   1       synchronous, active-high
//  prod_i      in   PROD_W  unsigned product from multiplier
//  prod_valid  in   1       prod_i valid
//  prod_ready  out  1       accumulator accepts prod_i this cycle
//  sum_o       out  ACC_W   group sum, registered
//  sum_valid   out  1       sum_o valid
//  sum_ready   in   1       downstream accepts sum_o
//  sat_o       out  1       group saturated (tied 0 without PRODUCT_ACC_SAT_EN)
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high. Everything is
//    evaluated at the rising edge of clk.
//  - Reset: state=ACCUM, acc=0, cnt=0, sum_o=0, sum_valid=0, sat_o=0, prod_ready=1
//    in the cycle after the reset edge.
//  - Reset mid-group or while HOLD discards partial acc/pending sum, no output.
//  - FSM states: ACCUM, HOLD.
//  - ACCUM: prod_ready=1, sum_valid=0. An accept is prod_valid&&prod_ready.
//    On accept: acc<=acc+prod_i, zero-extended to ACC_W, and cnt<=cnt+1.
//    Cycles with prod_valid=0 are bubbles: no change to acc or cnt.
//  - Accept with cnt==LEN-1: sum_o<=acc+prod_i, acc<=0, cnt<=0, then ->HOLD.
//    Latency: sum_valid=1 on the cycle after the last accept.
//  - HOLD: prod_ready=0, sum_valid=1. sum_o and sat_o are stable until the
//    handshake. On sum_ready: sum_valid<=0, then ->ACCUM; next product is
//    accepted one cycle later. prod_valid in HOLD is ignored and must be held
//    by upstream.
//  - Throughput: one group per LEN+1 cycles at best.
//  - Arithmetic: unsigned. Without the macro, sums wrap modulo 2^ACC_W.
// CONFIGURATION
//  - PRODUCT_ACC_SAT_EN defined: each add clamps to 2^ACC_W-1 on carry-out.
//    sat_o is sticky per group, set with sum_o if any add in the group clamped,
//    and cleared on the sum handshake.
//  - PRODUCT_ACC_SAT_EN undefined: plain wrap-around add; sat_o constant 0.
// STRUCTURE
//  - Package product_acc_pkg: PROD_W default constant, typedef enum logic
//    {ACCUM,HOLD} acc_state_t.
//  - Sub-module product_acc_add: combinational ACC_W adder. It returns the sum
//    and a clamp flag; saturation is under the macro.
//  - FSM, counter and registers live in product_accumulator.
// TESTING
//  1. LEN=4, products 1,2,3,4 back-to-back, sum_ready=1 -> sum_o=10, sat_o=0.
//     sum_valid is high for exactly 1 cycle, the cycle after the 4th accept.
//  2. 4 x 0xFE01 (255*255) -> sum_o=0x3F804. No wrap at ACC_W=18.
//  3. Hold sum_ready=0 for 5 cycles in HOLD -> sum_o stays constant, sum_valid=1,
//     prod_ready=0. sum_ready=1 -> prod_ready=1 next cycle.
//  4. Bubbles: valid pattern 1,0,0,1,1,0,1 with products 7 each -> sum_o=28.
//     Only the 4 valid cycles count.
//  5. Reset after 2 accepted products, then 4 x 5 -> sum_o=20, none of the
//     earlier data appears.
//  6. ACC_W=16, LEN=2, 2 x 0xFE01 -> macro off: sum_o=0xFC02, sat_o=0.
//     Macro on: sum_o=0xFFFF, sat_o=1, cleared after the handshake.

Source files
------------

// File: rtl/product_acc_pkg.sv
// Shared constants and state encoding for the product accumulator slice.
package product_acc_pkg;

  localparam int unsigned PROD_W_DEF = 16;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

endpackage

// File: rtl/product_acc_add.sv
// Combinational accumulator adder: acc + zero-extended product, with clamp flag.
// With PRODUCT_ACC_SAT_EN defined the add clamps to all-ones on carry-out.
module product_acc_add
  import product_acc_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned ACC_W  = 18
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              clamp
);

  logic [ACC_W-1:0] prod_ext;

  always_comb prod_ext = ACC_W'(prod);

`ifdef PRODUCT_ACC_SAT_EN
  logic [ACC_W:0] full;

  always_comb begin
    full  = {1'b0, acc} + {1'b0, prod_ext};
    clamp = full[ACC_W];
    sum   = clamp ? '1 : full[ACC_W-1:0];
  end
`else
  always_comb begin
    sum   = acc + prod_ext;
    clamp = 1'b0;
  end
`endif

endmodule

// File: rtl/product_accumulator.sv
// Sums LEN consecutive multiplier products and hands the total downstream.
// Optional saturation: PRODUCT_ACC_SAT_EN (otherwise wrap-around, sat_o = 0).
module product_accumulator
  import product_acc_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned LEN    = 4,
  parameter int unsigned ACC_W  = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PROD_W-1:0] prod_i,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  sum_o,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic              sat_o
);

  localparam int unsigned CNT_W = $clog2(LEN);

  acc_state_t       state, next_state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             sat_acc;
  logic [ACC_W-1:0] add_sum;
  logic             add_clamp;
  logic             accept;
  logic             last;

  product_acc_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .acc   (acc),
    .prod  (prod_i),
    .sum   (add_sum),
    .clamp (add_clamp)
  );

  always_comb begin
    next_state = state;
    prod_ready = 1'b0;
    sum_valid  = 1'b0;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      ACCUM: begin
        prod_ready = 1'b1;
        accept     = prod_valid;
        last       = prod_valid && (cnt == CNT_W'(LEN - 1));
        if (last) next_state = HOLD;
      end
      HOLD: begin
        sum_valid = 1'b1;
        if (sum_ready) next_state = ACCUM;
      end
      default: next_state = ACCUM;
    endcase
  end

  // sat_acc collects clamps of the group in flight; sat_o reports the finished group.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ACCUM;
      acc     <= '0;
      cnt     <= '0;
      sat_acc <= 1'b0;
      sum_o   <= '0;
      sat_o   <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        if (last) begin
          sum_o   <= add_sum;
          sat_o   <= sat_acc | add_clamp;
          acc     <= '0;
          cnt     <= '0;
          sat_acc <= 1'b0;
        end else begin
          acc     <= add_sum;
          cnt     <= cnt + 1'b1;
          sat_acc <= sat_acc | add_clamp;
        end
      end
      if (state == HOLD && sum_ready) sat_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator (default LEN=4/ACC_W=18 plus a LEN=2/ACC_W=16 instance).
module tb_product_accumulator;

  localparam int unsigned LEN     = 4;
  localparam int unsigned ACC_W   = 18;
  localparam int unsigned S_LEN   = 2;
  localparam int unsigned S_ACC_W = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [15:0]        prod_i;
  logic               prod_valid, prod_ready;
  logic [ACC_W-1:0]   sum_o;
  logic               sum_valid, sum_ready, sat_o;

  logic [15:0]        s_prod_i;
  logic               s_prod_valid, s_prod_ready;
  logic [S_ACC_W-1:0] s_sum_o;
  logic               s_sum_valid, s_sum_ready, s_sat_o;

  product_accumulator #(.PROD_W(16), .LEN(LEN), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .prod_i(prod_i), .prod_valid(prod_valid),
    .prod_ready(prod_ready), .sum_o(sum_o), .sum_valid(sum_valid),
    .sum_ready(sum_ready), .sat_o(sat_o)
  );

  product_accumulator #(.PROD_W(16), .LEN(S_LEN), .ACC_W(S_ACC_W)) dut_small (
    .clk(clk), .reset(reset), .prod_i(s_prod_i), .prod_valid(s_prod_valid),
    .prod_ready(s_prod_ready), .sum_o(s_sum_o), .sum_valid(s_sum_valid),
    .sum_ready(s_sum_ready), .sat_o(s_sat_o)
  );

  typedef struct {
    longint unsigned sum;
    bit              sat;
  } exp_t;

  exp_t            expq[$];
  longint unsigned grp[$];
  int unsigned     checks = 0;
  int unsigned     passes = 0;
  bit              rand_ready = 1'b0;

  function automatic void ref_group(input longint unsigned prods[$], input int unsigned accw,
                                    output longint unsigned s, output bit sat);
    longint unsigned maxv;
    maxv = (64'd1 << accw) - 64'd1;
    s    = 0;
    sat  = 1'b0;
    foreach (prods[i]) begin
      s = s + prods[i];
`ifdef PRODUCT_ACC_SAT_EN
      if (s > maxv) begin
        s   = maxv;
        sat = 1'b1;
      end
`else
      s = s & maxv;
`endif
    end
  endfunction

  function automatic void model_accept(input longint unsigned p);
    longint unsigned s;
    bit              sat;
    exp_t            e;
    grp.push_back(p);
    if (grp.size() == LEN) begin
      ref_group(grp, ACC_W, s, sat);
      e.sum = s;
      e.sat = sat;
      expq.push_back(e);
      grp.delete();
    end
  endfunction

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  // Called at a falling edge; returns at the falling edge after the product is taken.
  task automatic drive(input bit v, input logic [15:0] p);
    int unsigned waited;
    waited     = 0;
    prod_valid = v;
    prod_i     = p;
    if (rand_ready) sum_ready = 1'($urandom_range(0, 1));
    #1;
    if (v) begin
      while (!prod_ready && waited < 200) begin
        @(negedge clk);
        waited++;
        if (rand_ready) sum_ready = 1'($urandom_range(0, 1));
        #1;
      end
      if (prod_ready) model_accept(64'(p));
      else chk("accept_timeout", 64'(prod_ready), 1);
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_state();
    chk("rst_prod_ready", 64'(prod_ready), 1);
    chk("rst_sum_valid", 64'(sum_valid), 0);
    chk("rst_sum_o", 64'(sum_o), 0);
    chk("rst_sat_o", 64'(sat_o), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!reset && sum_valid && sum_ready) begin
        if (expq.size() == 0) begin
          chk("sb_unexpected_sum", 64'(sum_valid), 0);
        end else begin
          e = expq.pop_front();
          chk("sb_sum", 64'(sum_o), e.sum);
          chk("sb_sat", 64'(sat_o), 64'(e.sat));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin : stim
    logic [15:0] r;
    int unsigned waited;

    reset        = 1'b1;
    prod_valid   = 1'b0;
    prod_i       = '0;
    sum_ready    = 1'b1;
    s_prod_valid = 1'b0;
    s_prod_i     = '0;
    s_sum_ready  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_state();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 1: back-to-back 1..4, one-cycle sum_valid
    for (int i = 1; i <= 4; i++) drive(1'b1, 16'(i));
    prod_valid = 1'b0;
    #1;
    chk("t1_valid_after_last", 64'(sum_valid), 1);
    chk("t1_ready_low", 64'(prod_ready), 0);
    chk("t1_sum", 64'(sum_o), 10);
    @(negedge clk);
    #1;
    chk("t1_valid_one_cycle", 64'(sum_valid), 0);
    chk("t1_ready_back", 64'(prod_ready), 1);
    @(negedge clk);

    // 2: max products, no wrap at 18 bits
    for (int i = 0; i < 4; i++) drive(1'b1, 16'hFE01);
    prod_valid = 1'b0;
    #1;
    chk("t2_sum", 64'(sum_o), 64'h3F804);
    @(negedge clk);

    // 3: downstream stall in HOLD
    sum_ready = 1'b0;
    drive(1'b1, 16'd9);
    drive(1'b1, 16'd8);
    drive(1'b1, 16'd7);
    drive(1'b1, 16'd6);
    prod_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_hold_valid", 64'(sum_valid), 1);
      chk("t3_hold_ready", 64'(prod_ready), 0);
      chk("t3_hold_sum", 64'(sum_o), 30);
      @(negedge clk);
    end
    sum_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("t3_ready_after_hs", 64'(prod_ready), 1);
    @(negedge clk);

    // 4: bubbles
    drive(1'b1, 16'd7);
    drive(1'b0, 16'd99);
    drive(1'b0, 16'd99);
    drive(1'b1, 16'd7);
    drive(1'b1, 16'd7);
    drive(1'b0, 16'd99);
    drive(1'b1, 16'd7);
    prod_valid = 1'b0;
    #1;
    chk("t4_sum", 64'(sum_o), 28);
    @(negedge clk);

    // 5: reset mid-group discards partial sum
    drive(1'b1, 16'd11);
    drive(1'b1, 16'd13);
    prod_valid = 1'b0;
    reset      = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    grp.delete();
    #1;
    chk_reset_state();
    @(negedge clk);
    for (int i = 0; i < 4; i++) drive(1'b1, 16'd5);
    prod_valid = 1'b0;
    #1;
    chk("t5_sum", 64'(sum_o), 20);
    @(negedge clk);

    // random groups with bubbles and random downstream stalls
    rand_ready = 1'b1;
    for (int g = 0; g < 30; g++) begin
      for (int k = 0; k < int'(LEN); k++) begin
        if ($urandom_range(0, 3) == 0) drive(1'b0, 16'($urandom));
        r = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
        drive(1'b1, r);
      end
    end
    rand_ready = 1'b0;
    prod_valid = 1'b0;
    sum_ready  = 1'b1;
    waited     = 0;
    while (expq.size() != 0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("sb_drained", 64'(expq.size()), 0);
    @(negedge clk);

    // 6: LEN=2, ACC_W=16 instance with 2 x 0xFE01
    s_sum_ready  = 1'b0;
    s_prod_i     = 16'hFE01;
    s_prod_valid = 1'b1;
    #1;
    chk("t6_ready_first", 64'(s_prod_ready), 1);
    @(negedge clk);
    #1;
    chk("t6_ready_second", 64'(s_prod_ready), 1);
    @(negedge clk);
    s_prod_valid = 1'b0;
    #1;
    chk("t6_valid", 64'(s_sum_valid), 1);
`ifdef PRODUCT_ACC_SAT_EN
    chk("t6_sum", 64'(s_sum_o), 64'hFFFF);
    chk("t6_sat", 64'(s_sat_o), 1);
`else
    chk("t6_sum", 64'(s_sum_o), 64'hFC02);
    chk("t6_sat", 64'(s_sat_o), 0);
`endif
    @(negedge clk);
    s_sum_ready = 1'b1;
    @(negedge clk);
    s_sum_ready = 1'b0;
    #1;
    chk("t6_valid_cleared", 64'(s_sum_valid), 0);
    chk("t6_sat_cleared", 64'(s_sat_o), 0);
    chk("t6_ready_back", 64'(s_prod_ready), 1);
    @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
